// File: rtl/spi_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_if
// Brief    : Requester/engine-side signal bundle for spi_bus_arbiter.
//            'slave' is the arbiter's view, 'master' is the surroundings'.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_bus_arbiter_if #(
  parameter int NUM_REQUESTERS = 2
);
  logic [NUM_REQUESTERS-1:0]   req;
  logic [NUM_REQUESTERS-1:0]   grant;
  logic [NUM_REQUESTERS-1:0]   xfer_valid;
  logic [8*NUM_REQUESTERS-1:0] xfer_data;
  logic [NUM_REQUESTERS-1:0]   xfer_ready;
  logic [NUM_REQUESTERS-1:0]   rx_valid;
  logic [7:0]                  rx_data;
  logic                        eng_start;
  logic [7:0]                  eng_tx_data;
  logic                        eng_done;
  logic [7:0]                  eng_rx_data;
  logic [NUM_REQUESTERS-1:0]   cs_n;
  logic                        timeout;

  modport slave (
    input  req, xfer_valid, xfer_data, eng_done, eng_rx_data,
    output grant, xfer_ready, rx_valid, rx_data, eng_start, eng_tx_data,
           cs_n, timeout
  );

  modport master (
    output req, xfer_valid, xfer_data, eng_done, eng_rx_data,
    input  grant, xfer_ready, rx_valid, rx_data, eng_start, eng_tx_data,
           cs_n, timeout
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Brief    : Round-robin arbiter sharing one SPI byte engine among
//            NUM_REQUESTERS masters. Locks the bus for a whole transaction
//            and frames it with chip-select setup and hold periods.
//            Optional idle-lock watchdog: define SPI_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic             clock,
  input  logic             reset,
  spi_bus_arbiter_if.slave bus
);

  localparam int N       = NUM_REQUESTERS;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int MAX_SH  = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [IW-1:0]    LAST_RST   = IW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     cs_n_q, cs_n_d;
  logic [N-1:0]     rx_valid_q, rx_valid_d;
  logic [IW-1:0]    last_q, last_d;      // owner while a transaction is open
  logic [CNT_W-1:0] cnt_q, cnt_d;        // shared setup/hold counter
  logic             byte_done_q, byte_done_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             eng_start_q, eng_start_d;
  logic [7:0]       eng_tx_data_q, eng_tx_data_d;

  logic [N-1:0]     req_eff;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    scan_idx;
  logic             win_found;
  logic [7:0]       tx_bytes [N];

  generate
    for (genvar i = 0; i < N; i++) begin : g_unpack
      assign tx_bytes[i] = bus.xfer_data[8*i +: 8];
    end
  endgenerate

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [N-1:0]     blocked_q, blocked_d;  // revoked requesters awaiting a req drop
  logic             timeout_q, timeout_d;

  assign req_eff     = bus.req & ~blocked_q;
  assign bus.timeout = timeout_q;

  // Watchdog state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign req_eff     = bus.req;
  assign bus.timeout = 1'b0;
`endif

  // Round-robin search starting one past the previous winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    scan_idx  = last_q;
    for (int k = 1; k <= N; k++) begin
      scan_idx = IW'((int'(last_q) + k) % N);
      if (!win_found && req_eff[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      cs_n_q        <= '1;
      rx_valid_q    <= '0;
      last_q        <= LAST_RST;
      cnt_q         <= '0;
      byte_done_q   <= 1'b0;
      rx_data_q     <= '0;
      eng_start_q   <= 1'b0;
      eng_tx_data_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cs_n_q        <= cs_n_d;
      rx_valid_q    <= rx_valid_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      byte_done_q   <= byte_done_d;
      rx_data_q     <= rx_data_d;
      eng_start_q   <= eng_start_d;
      eng_tx_data_q <= eng_tx_data_d;
    end
  end

  // Transaction sequencer: next state and registered outputs
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cs_n_d        = cs_n_q;
    rx_valid_d    = '0;
    last_d        = last_q;
    cnt_d         = cnt_q;
    byte_done_d   = 1'b0;
    rx_data_d     = rx_data_q;
    eng_start_d   = 1'b0;
    eng_tx_data_d = eng_tx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_cnt_d      = '0;
    blocked_d     = blocked_q & bus.req;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          cs_n_d           = ~grant_d;
          last_d           = win_idx;
          cnt_d            = '0;
          state_d          = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!bus.req[last_q]) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (bus.xfer_valid[last_q]) begin
          eng_start_d   = 1'b1;
          eng_tx_data_d = tx_bytes[last_q];
          state_d       = ST_WAIT_DONE;
        end else if (!bus.req[last_q]) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) begin
          timeout_d         = 1'b1;
          blocked_d[last_q] = 1'b1;
          cnt_d             = '0;
          state_d           = ST_HOLD;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_WAIT_DONE: begin
        // Linger one cycle after completion so ready follows rx_valid
        if (byte_done_q) begin
          state_d = ST_ACTIVE;
        end else if (bus.eng_done) begin
          rx_data_d   = bus.eng_rx_data;
          rx_valid_d  = grant_q;
          byte_done_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          grant_d = '0;
          cs_n_d  = '1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        cs_n_d  = '1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.xfer_ready  = (state_q == ST_ACTIVE) ? grant_q : '0;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_tx_data = eng_tx_data_q;

endmodule
`default_nettype wire
